// File: rtl/loopback_ctrl_if.sv
// loopback_ctrl_if: host read/write channels and loopback FIFO control seen by the sequencer.
interface loopback_ctrl_if #(
  parameter int ADDR_WIDTH = 42,
  parameter int CNT_WIDTH  = 4
);
  logic                  rd_req_valid;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic                  rd_req_almost_full;
  logic                  rd_rsp_valid;
  logic                  wr_req_valid;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic                  wr_req_almost_full;
  logic                  wr_rsp_valid;
  logic                  fifo_enq_en;
  logic                  fifo_deq_en;
  logic                  fifo_empty;
  logic [CNT_WIDTH-1:0]  fifo_count;
  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, fifo_enq_en, fifo_deq_en,
    input  rd_req_almost_full, rd_rsp_valid, wr_req_almost_full, wr_rsp_valid, fifo_empty, fifo_count
  );
  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, fifo_enq_en, fifo_deq_en,
    output rd_req_almost_full, rd_rsp_valid, wr_req_almost_full, wr_rsp_valid, fifo_empty, fifo_count
  );
endinterface

// File: rtl/loopback_ctrl.sv
// loopback_ctrl: copies num_lines cache lines src->dst through the loopback FIFO with credit-gated reads.
module loopback_ctrl #(
  parameter int ADDR_WIDTH = 42,
  parameter int LEN_WIDTH  = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  num_lines,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  loopback_ctrl_if.master       bus
);
  localparam int OW = LEN_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] src, dst;
  logic [LEN_WIDTH-1:0]  num, rd_sent, rd_rcvd, wr_sent, wr_rcvd;
  logic [CNT_WIDTH-1:0]  fcount;
  logic [OW-1:0]         occ;
  logic err, armed, start_acc, live, rd_issue, enq, wr_issue, ack, err_set;
  assign fcount = bus.fifo_count;
  always_comb begin
    start_acc = state == IDLE && start;
    live      = state == RUN || state == DRAIN;
    // FIFO occupancy plus reads still in flight must stay within usable capacity
    occ       = OW'(fcount) + OW'(rd_sent - rd_rcvd);
    rd_issue  = state == RUN && rd_sent < num && !bus.rd_req_almost_full && occ < OW'(FIFO_DEPTH - 1);
    enq       = live && bus.rd_rsp_valid && rd_rcvd < num;
    wr_issue  = state == RUN && !bus.fifo_empty && !bus.wr_req_almost_full && wr_sent < num;
    ack       = live && bus.wr_rsp_valid && wr_rcvd < num;
    // stray responses only count once a job has been accepted since the last reset
    err_set   = armed && ((bus.rd_rsp_valid && !enq) || (bus.wr_rsp_valid && !ack));
    state_nx  = state;
    case (state)
      IDLE:    state_nx = start ? (num_lines != '0 ? RUN : DONE) : IDLE;
      RUN:     state_nx = wr_sent + LEN_WIDTH'(wr_issue) == num ? DRAIN : RUN;
      DRAIN:   state_nx = wr_rcvd + LEN_WIDTH'(ack) == num ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      rd_sent <= '0;
      rd_rcvd <= '0;
      wr_sent <= '0;
      wr_rcvd <= '0;
      err     <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_acc) begin
        src     <= src_addr;
        dst     <= dst_addr;
        num     <= num_lines;
        rd_sent <= '0;
        rd_rcvd <= '0;
        wr_sent <= '0;
        wr_rcvd <= '0;
        err     <= 1'b0;
        armed   <= 1'b1;
      end else begin
        rd_sent <= rd_sent + LEN_WIDTH'(rd_issue);
        rd_rcvd <= rd_rcvd + LEN_WIDTH'(enq);
        wr_sent <= wr_sent + LEN_WIDTH'(wr_issue);
        wr_rcvd <= wr_rcvd + LEN_WIDTH'(ack);
        err     <= err | err_set;
      end
    end
  end
  assign busy             = state != IDLE;
  assign done             = state == DONE;
  assign error            = err;
  assign bus.rd_req_valid = rd_issue;
  assign bus.rd_req_addr  = src + ADDR_WIDTH'(rd_sent);
  assign bus.fifo_enq_en  = enq;
  assign bus.wr_req_valid = wr_issue;
  assign bus.fifo_deq_en  = wr_issue;
  assign bus.wr_req_addr  = dst + ADDR_WIDTH'(wr_sent);
endmodule

// File: tb/tb_loopback_ctrl.sv
// tb_loopback_ctrl: host/FIFO environment plus per-job reference expectations for loopback_ctrl.
module tb_loopback_ctrl;
  localparam int AW = 42, LW = 32, FD = 8, CW = 4;
  logic clk = 0, reset_n = 0, start = 0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [LW-1:0] num_lines = '0;
  logic busy, done, error;
  loopback_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus();
  loopback_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .num_lines(num_lines), .busy(busy), .done(done), .error(error), .bus(bus)
  );
  always #5 clk = ~clk;
  logic rd_af = 0, wr_af = 0, inj_rd = 0, inj_wr = 0;
  logic [15:0] rd_sr = '0, wr_sr = '0;
  int rd_lat = 3, wr_lat = 2, mode = 0;
  int fifo_cnt = 0;
  int fifo_q[$];
  assign bus.rd_req_almost_full = rd_af;
  assign bus.wr_req_almost_full = wr_af;
  assign bus.rd_rsp_valid = rd_sr[rd_lat-1] | inj_rd;
  assign bus.wr_rsp_valid = wr_sr[wr_lat-1] | inj_wr;
  assign bus.fifo_empty = fifo_cnt == 0;
  assign bus.fifo_count = CW'(fifo_cnt);
  logic [AW-1:0] j_src = '0, j_dst = '0, last_rd = '0;
  int rd_n = 0, wr_n = 0, enq_n = 0, ack_n = 0, done_n = 0, ack_at_done = 0;
  int bad_addr = 0, bad_bp = 0, bad_data = 0, ovf = 0;
  // host latency pipes, FIFO model and per-job bookkeeping
  always @(posedge clk) begin
    rd_sr <= {rd_sr[14:0], bus.rd_req_valid};
    wr_sr <= {wr_sr[14:0], bus.wr_req_valid};
    if (!reset_n) begin
      fifo_cnt <= 0;
      fifo_q.delete();
      rd_n <= 0; wr_n <= 0; enq_n <= 0; ack_n <= 0;
    end else begin
      if (start && !busy) begin
        j_src <= src_addr; j_dst <= dst_addr;
        rd_n <= 0; wr_n <= 0; enq_n <= 0; ack_n <= 0; done_n <= 0;
        fifo_q.delete();
      end
      if (fifo_cnt + (rd_n - enq_n) > FD - 1) ovf <= ovf + 1;
      if (bus.rd_req_valid) begin
        if (bus.rd_req_addr !== j_src + AW'(rd_n)) bad_addr <= bad_addr + 1;
        if (rd_af) bad_bp <= bad_bp + 1;
        last_rd <= bus.rd_req_addr;
        rd_n <= rd_n + 1;
      end
      if (bus.fifo_deq_en !== bus.wr_req_valid) bad_data <= bad_data + 1;
      if (bus.wr_req_valid) begin
        if (bus.wr_req_addr !== j_dst + AW'(wr_n) || wr_af) bad_bp <= bad_bp + 1;
        if (fifo_q.size() == 0) bad_data <= bad_data + 1;
        else if (fifo_q.pop_front() != wr_n) bad_data <= bad_data + 1;
        wr_n <= wr_n + 1;
      end
      if (bus.fifo_enq_en) begin
        if (fifo_cnt >= FD - 1) ovf <= ovf + 1;
        fifo_q.push_back(enq_n);
        enq_n <= enq_n + 1;
      end
      if (bus.wr_rsp_valid && !inj_wr) ack_n <= ack_n + 1;
      if (done) begin
        done_n <= done_n + 1;
        ack_at_done <= ack_n;
      end
      fifo_cnt <= fifo_cnt + int'(bus.fifo_enq_en) - int'(bus.fifo_deq_en);
    end
  end
  int n_chk = 0, n_fail = 0;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    case (mode)
      1: begin rd_af = $urandom_range(0, 3) == 0; wr_af = $urandom_range(0, 3) == 0; end
      2: begin rd_af = ~rd_af; wr_af = ~wr_af; end
      3: begin rd_af = 0; wr_af = 1; end
      default: begin rd_af = 0; wr_af = 0; end
    endcase
  endtask
  task automatic start_job(logic [AW-1:0] s, logic [AW-1:0] d, logic [LW-1:0] n);
    start = 1; src_addr = s; dst_addr = d; num_lines = n;
    step();
    start = 0;
  endtask
  task automatic finish_job(string tag, int n);
    int k = 0;
    while (done_n == 0 && k < 3000) begin step(); k++; end
    chk({tag, " timeout"}, k < 3000, 1);
    mode = 0;
    repeat (wr_lat + 3) step();
    chk({tag, " rd count"}, rd_n, n);
    chk({tag, " wr count"}, wr_n, n);
    chk({tag, " done pulses"}, done_n, 1);
    chk({tag, " acks at done"}, ack_at_done, n);
    chk({tag, " error"}, error, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " violations"}, bad_addr + bad_bp + bad_data + ovf, 0);
  endtask
  initial begin
    repeat (3) step();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset error", error, 0);
    chk("reset strobes", {bus.rd_req_valid, bus.wr_req_valid, bus.fifo_enq_en, bus.fifo_deq_en}, 0);
    reset_n = 1;
    step();
    start_job(42'h1000, 42'h2000, 20);
    repeat (6) step();
    reset_n = 0;
    step();
    reset_n = 1;
    chk("midreset busy", busy, 0);
    chk("midreset strobes", {bus.rd_req_valid, bus.wr_req_valid, bus.fifo_enq_en, bus.fifo_deq_en}, 0);
    inj_rd = 1;
    step();
    inj_rd = 0;
    repeat (8) step();
    chk("midreset stray rsp error", error, 0);
    chk("midreset idle strobes", {bus.rd_req_valid, bus.wr_req_valid}, 0);
    start_job(42'h5, 42'h6, 0);
    chk("zero done", done, 1);
    chk("zero busy", busy, 1);
    step();
    chk("zero done end", done, 0);
    chk("zero busy end", busy, 0);
    chk("zero requests", rd_n + wr_n, 0);
    chk("zero done pulses", done_n, 1);
    start_job(42'h100, 42'h200, 4);
    chk("basic first rd valid", bus.rd_req_valid, 1);
    chk("basic first rd addr", bus.rd_req_addr, 42'h100);
    finish_job("basic", 4);
    mode = 3;
    start_job(42'h40, 42'h80, 32);
    repeat (25) step();
    chk("credit reads", rd_n, FD - 1);
    chk("credit rd valid", bus.rd_req_valid, 0);
    chk("credit fifo full", fifo_cnt, FD - 1);
    mode = 1;
    finish_job("credit", 32);
    mode = 2;
    start_job({AW{1'b1}} - 42'd1, 42'h300, 4);
    finish_job("wrap", 4);
    chk("wrap last rd addr", last_rd, 42'h1);
    for (int j = 0; j < 6; j++) begin
      int n;
      rd_lat = $urandom_range(1, 6);
      wr_lat = $urandom_range(1, 6);
      n = $urandom_range(1, 40);
      mode = 1;
      start_job({$urandom, $urandom}, {$urandom, $urandom}, LW'(n));
      finish_job($sformatf("rand%0d", j), n);
    end
    inj_wr = 1;
    step();
    inj_wr = 0;
    step();
    chk("extra ack error", error, 1);
    repeat (3) step();
    chk("error sticky", error, 1);
    start_job(42'h700, 42'h900, 3);
    chk("start clears error", error, 0);
    finish_job("after error", 3);
    inj_rd = 1;
    step();
    inj_rd = 0;
    step();
    chk("idle rd rsp error", error, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/loopback_ctrl.md
Name: loopback_ctrl

Overview:
Sequencer for the loopback datapath. On `start` it copies `num_lines` cache lines from `src_addr` to `dst_addr`:
- issues line reads to the host read channel;
- steers read responses into the loopback FIFO;
- drains the FIFO onto the host write channel;
- reports completion once every write is acknowledged.

Read issue is credit-gated on FIFO free space, so the FIFO never overflows. The block sits between the host request/response channels and the loopback FIFO.

Parameters:
- ADDR_WIDTH, 42, cache-line address width.
- LEN_WIDTH, 32, width of line counters.
- FIFO_DEPTH, 8, depth of the attached FIFO. Usable capacity is FIFO_DEPTH-1 (the FIFO reports full at count FIFO_DEPTH-1).
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of the FIFO occupancy input.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle job start; honoured only in IDLE.
- src_addr  in  ADDR_WIDTH  source line address; sampled on accepted start.
- dst_addr  in  ADDR_WIDTH  destination line address; sampled on accepted start.
- num_lines  in  LEN_WIDTH  lines to copy; sampled on accepted start.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky unexpected-response flag; cleared on accepted start.
- rd_req_valid  out  1  issue read this cycle.
- rd_req_addr  out  ADDR_WIDTH  read line address.
- rd_req_almost_full  in  1  host read backpressure.
- rd_rsp_valid  in  1  read data returning this cycle.
- wr_req_valid  out  1  issue write this cycle; data is the FIFO head.
- wr_req_addr  out  ADDR_WIDTH  write line address.
- wr_req_almost_full  in  1  host write backpressure.
- wr_rsp_valid  in  1  write acknowledged this cycle.
- fifo_enq_en  out  1  FIFO enqueue strobe.
- fifo_deq_en  out  1  FIFO dequeue strobe.
- fifo_empty  in  1  FIFO empty.
- fifo_count  in  CNT_WIDTH  FIFO occupancy; updates the cycle after enq/deq.

Behaviour:
- Reset (reset_n=0 at posedge, any state, mid-job included):
  - state=IDLE; counters rd_sent, rd_rcvd, wr_sent, wr_rcvd = 0.
  - busy, done, error = 0.
  - All strobes (rd_req_valid, wr_req_valid, fifo_enq_en, fifo_deq_en) = 0.
  - In-flight responses arriving after reset are ignored and do not set error.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start: latch src/dst/num, clear the four counters and error.
  - Next state is RUN if num_lines != 0, else DONE.
  - start in any other state is ignored.
- RUN, read issue:
  - rd_req_valid=1 iff rd_sent < num, !rd_req_almost_full, and fifo_count + (rd_sent - rd_rcvd) < FIFO_DEPTH-1.
  - rd_req_addr = src + rd_sent, modulo 2^ADDR_WIDTH.
  - rd_sent increments on each issue.
- Read responses (RUN and DRAIN):
  - fifo_enq_en = rd_rsp_valid && rd_rcvd < num; rd_rcvd increments.
  - rd_rsp_valid when rd_rcvd == num, or in IDLE/DONE: no enqueue, error<=1.
- RUN, write issue:
  - wr_req_valid = fifo_deq_en = (!fifo_empty && !wr_req_almost_full && wr_sent < num). Combinational from current state/inputs, same cycle as the dequeue.
  - wr_req_addr = dst + wr_sent, modulo 2^ADDR_WIDTH.
  - wr_sent increments on each issue.
- Simultaneity: read issue, response enqueue, write issue and write ack may all occur in one cycle; each counter updates independently.
- Credit invariant: fifo_count + outstanding reads <= FIFO_DEPTH-1 at all times. fifo_enq_en is never asserted while the FIFO is full.
- RUN -> DRAIN when wr_sent reaches num. The last write issue takes effect the same cycle.
- Write acks:
  - wr_rsp_valid increments wr_rcvd while wr_rcvd < num.
  - Otherwise (extra ack, or ack in IDLE/DONE): error<=1.
- DRAIN -> DONE when wr_rcvd == num. An ack counted in the same cycle it reaches num qualifies.
- DONE: done=1 for exactly one cycle, busy=1; next state IDLE unconditionally.
- Latency: first rd_req_valid appears the cycle after an accepted start, given credit and no backpressure. Minimum job time for N lines is N + host latency + 2 cycles.
- Counters never wrap within a job; num_lines max 2^LEN_WIDTH-1.

Test Plan:
- Reset mid-job: start num=20, assert reset_n=0 after 7 cycles -> next cycle busy=0, all strobes 0, counters 0. A later rd_rsp_valid does not set error.
- Zero-length job: start, num=0 -> DONE the next cycle, done pulses once, no rd/wr requests, busy returns to 0 two cycles after start.
- Basic copy: src=0x100, dst=0x200, num=4, 3-cycle read latency, no backpressure -> reads 0x100..0x103, writes 0x200..0x203 in order, done pulses once after the 4th ack.
- Credit gating: FIFO_DEPTH=8, num=32, wr_req_almost_full held high -> exactly 7 reads issued, then rd_req_valid stays 0. Release backpressure -> traffic resumes, done after 32 acks.
- Backpressure and address wrap: src=2^42-2, num=4, toggle rd/wr almost_full every other cycle -> rd addrs 2^42-2, 2^42-1, 0, 1. No request ever issued while its almost_full is high.
- Error cases: extra wr_rsp_valid after done -> error=1 and stays set; a new start clears it and the job completes normally.
